inv_burst_writer: RTL
=====================

# inv_burst_writer

Initiator side of the multi-operand Montgomery inverter's write/start interface. Collects (address, operand) pairs from an upstream valid/ready stream into an internal buffer, then replays them to the inverter as one contiguous burst with start held high. After the burst it tracks the inverter's busy flag through acknowledge and completion, and only then accepts the next burst. Sits between the pairing datapath's operand producer and the inverter.

## Interface
- DATA_W, 288: operand width; matches the inverter's write-data width.
- ADDR_W, 9: operand-slot address width.
- MAX_BURST, 16: buffer depth; maximum writes per burst.
- ACK_TO, 8: cycles allowed for busy to rise after the burst ends.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- S_VALID  in  1  upstream pair valid.
- S_READY  out  1  block can accept a pair.
- S_ADDR  in  ADDR_W  slot address.
- S_DATA  in  DATA_W  operand.
- S_LAST  in  1  last pair of this burst.
- O_START  out  1  inverter start/write strobe; high on every burst write cycle.
- O_WADDR  out  ADDR_W  write address to inverter.
- O_WDATA  out  DATA_W  write data to inverter.
- I_BUSY  in  1  inverter busy.
- O_DONE  out  1  one-cycle pulse when the inverter finishes a burst.
- O_ACK_TIMEOUT  out  1  one-cycle pulse when busy never rose within ACK_TO.

## Operation
- States: IDLE, COLLECT, ARM, ISSUE, ACK, DONE.
- S_READY = 1 only in IDLE and COLLECT. A pair is accepted on S_VALID & S_READY and written to buffer[wcnt]; wcnt increments.
- IDLE -> COLLECT on the first accept, unless that pair has S_LAST, which goes straight to ARM.
- COLLECT -> ARM on accepting a pair with S_LAST, or when the accept makes wcnt == MAX_BURST. A forced close ignores S_LAST on later pairs; they start a new burst.
- ARM: waits for I_BUSY == 0, then goes to ISSUE with rcnt = 0.
- ISSUE:
  - Each cycle drives O_START=1 with O_WADDR/O_WDATA = buffer[rcnt], then increments rcnt.
  - Writes are emitted back to back, in acceptance order, with no gaps. Duplicate addresses are replayed as-is.
  - After wcnt cycles the state goes to ACK and O_START drops.
- ACK: waits for I_BUSY == 1, then goes to DONE.
  - The counter starts at 0 on entry.
  - If ACK_TO cycles pass with no busy, the block pulses O_ACK_TIMEOUT and O_DONE and returns to IDLE.
- DONE: on I_BUSY == 0, pulses O_DONE, clears wcnt and returns to IDLE.
- I_BUSY is ignored in IDLE, COLLECT and ISSUE.
- O_WADDR/O_WDATA hold their last driven value outside ISSUE. O_START is the only qualifier.
- Counters are clog2(MAX_BURST)+1 bits wide. wcnt never exceeds MAX_BURST.

## Timing
- Reset values: S_READY=0, O_START=0, O_WADDR=0, O_WDATA=0, O_DONE=0, O_ACK_TIMEOUT=0; state IDLE, wcnt=rcnt=0. S_READY rises in the first cycle after rst deasserts.
- All outputs are registered.
- Last pair accepted at edge t: state is ARM after t.
  - If I_BUSY=0 at edge t+1, O_START is high from edge t+2 through t+1+wcnt.
  - Minimum latency from last accept to first write is 2 cycles.
- I_BUSY high at ACK edge u: DONE from u+1. The first edge in DONE that samples I_BUSY=0 asserts O_DONE for exactly one cycle, and S_READY also rises at that edge.
- Timeout: O_ACK_TIMEOUT and O_DONE assert together, on the ACK_TO-th edge after entering ACK.
- Reset mid-burst: at the next edge O_START=0 and the buffer contents are discarded. No partial burst resumes.

## Test plan
- Single burst of 3 pairs, addresses 0x11, 0x12, 0x13, S_LAST on the third, I_BUSY=0:
  - O_START is high exactly 3 consecutive cycles with the same addresses and data in order.
  - Busy high 20 cycles then low -> one O_DONE pulse. S_READY stays low from the last accept until O_DONE.
- Busy held high (previous job) when the burst is ARM'd: no O_START until busy falls, then the write starts 1 cycle later.
- Forced close: 18 pairs with no S_LAST (MAX_BURST=16):
  - First burst has 16 writes.
  - After O_DONE, the remaining 2 pairs form a second burst once S_LAST is given.
- Single-pair burst (addr 0x22, S_LAST=1 on first accept): skips COLLECT; one O_START cycle.
- Busy never rises after the burst: O_ACK_TIMEOUT and O_DONE both pulse on the 8th ACK edge, then back to IDLE with S_READY=1.
- rst asserted during the 2nd ISSUE cycle of a 5-write burst:
  - O_START=0 the next cycle and all outputs return to reset values.
  - A fresh 2-pair burst afterwards emits only the new data.

Source files
------------

// File: rtl/inv_burst_writer.sv
// Buffers upstream (address, operand) pairs and replays them to the Montgomery
// inverter as one gap-free start/write burst, then tracks busy through ack and completion.
//
// state   | meaning
// IDLE    | empty buffer, waiting for the first pair
// COLLECT | accepting further pairs of the current burst
// ARM     | burst closed, waiting for the inverter to go idle
// ISSUE   | replaying buffer entries with O_START high
// ACK     | waiting for busy to rise, bounded by ACK_TO
// DONE    | waiting for busy to fall
module inv_burst_writer #(
  parameter int DATA_W    = 288,
  parameter int ADDR_W    = 9,
  parameter int MAX_BURST = 16,
  parameter int ACK_TO    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [ADDR_W-1:0] S_ADDR,
  input  logic [DATA_W-1:0] S_DATA,
  input  logic              S_LAST,
  output logic              O_START,
  output logic [ADDR_W-1:0] O_WADDR,
  output logic [DATA_W-1:0] O_WDATA,
  input  logic              I_BUSY,
  output logic              O_DONE,
  output logic              O_ACK_TIMEOUT
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam logic [CW-1:0] L_MAX     = CW'(MAX_BURST);
  localparam logic [TW-1:0] L_TO_LAST = TW'(ACK_TO - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_COLLECT, ST_ARM, ST_ISSUE, ST_ACK, ST_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_wcnt, w_wcnt_nxt;
  logic [CW-1:0]     r_rcnt, w_rcnt_nxt;
  logic [TW-1:0]     r_ack_cnt, w_ack_cnt_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_start, w_start_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_done, w_done_nxt;
  logic              r_to, w_to_nxt;

  logic [ADDR_W-1:0] r_buf_addr [MAX_BURST];
  logic [DATA_W-1:0] r_buf_data [MAX_BURST];

  logic              w_accept;
  logic [CW-1:0]     w_wcnt_inc;
  logic [CW-1:0]     w_rcnt_inc;

  assign w_accept   = S_VALID & r_ready;
  assign w_wcnt_inc = r_wcnt + 1'b1;
  assign w_rcnt_inc = r_rcnt + 1'b1;

  // Buffer contents need no reset: clearing wcnt discards them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_addr[r_wcnt[IW-1:0]] <= S_ADDR;
      r_buf_data[r_wcnt[IW-1:0]] <= S_DATA;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_rcnt_nxt    = r_rcnt;
    w_ack_cnt_nxt = r_ack_cnt;
    w_start_nxt   = 1'b0;
    w_waddr_nxt   = r_waddr;
    w_wdata_nxt   = r_wdata;
    w_done_nxt    = 1'b0;
    w_to_nxt      = 1'b0;
    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        if (w_accept) begin
          w_wcnt_nxt = w_wcnt_inc;
          if (S_LAST || (w_wcnt_inc == L_MAX)) w_state_nxt = ST_ARM;
          else                                 w_state_nxt = ST_COLLECT;
        end
      end
      ST_ARM: begin
        if (!I_BUSY) begin
          w_state_nxt = ST_ISSUE;
          w_rcnt_nxt  = '0;
        end
      end
      ST_ISSUE: begin
        w_start_nxt = 1'b1;
        w_waddr_nxt = r_buf_addr[r_rcnt[IW-1:0]];
        w_wdata_nxt = r_buf_data[r_rcnt[IW-1:0]];
        w_rcnt_nxt  = w_rcnt_inc;
        if (w_rcnt_inc == r_wcnt) begin
          w_state_nxt   = ST_ACK;
          w_ack_cnt_nxt = '0;
        end
      end
      ST_ACK: begin
        if (I_BUSY) begin
          w_state_nxt = ST_DONE;
        end else if (r_ack_cnt == L_TO_LAST) begin
          w_to_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
          w_wcnt_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_ack_cnt_nxt = r_ack_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (!I_BUSY) begin
          w_done_nxt  = 1'b1;
          w_wcnt_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_ack_cnt <= '0;
      r_ready   <= 1'b0;
      r_start   <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
      r_to      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_ack_cnt <= w_ack_cnt_nxt;
      r_ready   <= w_ready_nxt;
      r_start   <= w_start_nxt;
      r_waddr   <= w_waddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_done    <= w_done_nxt;
      r_to      <= w_to_nxt;
    end
  end

  assign S_READY       = r_ready;
  assign O_START       = r_start;
  assign O_WADDR       = r_waddr;
  assign O_WDATA       = r_wdata;
  assign O_DONE        = r_done;
  assign O_ACK_TIMEOUT = r_to;

endmodule
